// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus plus UART-style RX/TX streams and status lines
// between the CPU core (master) and the memory/io responder (slave).
interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic        tx_overflow;

  modport master (
    output cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
    input  cpu_din, io_buffer_full, rx_ready, tx_valid, tx_data, halt, tx_overflow
  );

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
    output cpu_din, io_buffer_full, rx_ready, tx_valid, tx_data, halt, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM below the io window, UART in/out,
// free-running cycle counter with snapshot, and a sticky program-stop port.
// Every cycle is one access; reads return data one cycle later.
module mem_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input logic              clk_in,
  input logic              rst_in,
  mem_io_responder_if.slave bus
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  // Address decode: io window is a[17:16]==2'b11, offset in a[15:0]
  logic                  io_sel;
  logic [15:0]           io_off;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  rd_en;
  logic                  unused_addr_bits;

  assign io_sel           = (bus.cpu_a[17:16] == 2'b11);
  assign io_off           = bus.cpu_a[15:0];
  assign ram_addr         = bus.cpu_a[ADDR_WIDTH-1:0];
  assign rd_en            = rst_in && !bus.cpu_wr;
  assign unused_addr_bits = ^bus.cpu_a[31:18];

  // Byte RAM (no reset, registered read for block-RAM inference)
  logic [7:0] ram [0:(1 << ADDR_WIDTH) - 1];
  logic [7:0] ram_rd_reg;
  logic       ram_we;

  assign ram_we = rst_in && !io_sel && bus.cpu_wr;

  // RAM write port and registered read port
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= bus.cpu_dout;
    ram_rd_reg <= ram[ram_addr];
  end

  // Cycle counter and its snapshot for multi-byte reads
  logic [31:0] cycle_cnt_reg;
  logic [31:0] snap_reg;

  // Counter advances every cycle; a 0x30004 read latches the pre-increment value
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cycle_cnt_reg <= '0;
      snap_reg      <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (io_sel && !bus.cpu_wr && io_off == 16'h0004) snap_reg <= cycle_cnt_reg;
    end
  end

  // io read data selection
  logic [7:0] io_rd_next;

  // Byte returned for an io read; zero for writes and unmapped offsets
  always_comb begin
    io_rd_next = 8'h00;
    if (io_sel && !bus.cpu_wr) begin
      case (io_off)
        16'h0000: io_rd_next = bus.rx_valid ? bus.rx_data : 8'h00;
        16'h0004: io_rd_next = cycle_cnt_reg[7:0];
        16'h0005: io_rd_next = snap_reg[15:8];
        16'h0006: io_rd_next = snap_reg[23:16];
        16'h0007: io_rd_next = snap_reg[31:24];
        default:  io_rd_next = 8'h00;
      endcase
    end
  end

  assign bus.rx_ready = rd_en && io_sel && (io_off == 16'h0000) && bus.rx_valid;

  logic       rd_sel_ram_reg;
  logic [7:0] io_rd_reg;

  // Registered read path; reset forces an in-flight read to return zero
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_sel_ram_reg <= 1'b0;
      io_rd_reg      <= 8'h00;
    end else begin
      rd_sel_ram_reg <= !io_sel && !bus.cpu_wr;
      io_rd_reg      <= io_rd_next;
    end
  end

  assign bus.cpu_din = rd_sel_ram_reg ? ram_rd_reg : io_rd_reg;

  // TX FIFO and stop port
  logic [7:0]    fifo_mem [0:TX_DEPTH-1];
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, full_next;
  logic          overflow_reg;
  logic          halt_reg;
  logic          io_wr_en, push_req, push_ok, pop;
  logic [7:0]    push_data;
  logic [31:0]   free_next;

  // Push/pop decisions; io writes are locked out once halted
  always_comb begin
    io_wr_en   = rst_in && io_sel && bus.cpu_wr && !halt_reg;
    push_req   = io_wr_en && ((io_off == 16'h0000 && bus.cpu_dout != 8'h00) ||
                              io_off == 16'h0004);
    push_data  = (io_off == 16'h0004) ? 8'h00 : bus.cpu_dout;
    pop        = (count_reg != '0) && bus.tx_ready;
    push_ok    = push_req && ((count_reg != CW'(TX_DEPTH)) || pop);
    count_next = count_reg + CW'(push_ok) - CW'(pop);
    free_next  = 32'(TX_DEPTH) - 32'(count_next);
    full_next  = (free_next <= 32'(FULL_MARGIN));
  end

  // FIFO storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[tail_reg] <= push_data;
  end

  // FIFO pointers, near-full flag and sticky status bits
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      halt_reg     <= 1'b0;
    end else begin
      if (push_ok) tail_reg <= tail_reg + 1'b1;
      if (pop)     head_reg <= head_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= full_next;
      if (push_req && !push_ok) overflow_reg <= 1'b1;
      if (io_wr_en && io_off == 16'h0004) halt_reg <= 1'b1;
    end
  end

  assign bus.tx_valid       = (count_reg != '0);
  assign bus.tx_data        = fifo_mem[head_reg];
  assign bus.io_buffer_full = full_reg;
  assign bus.tx_overflow    = overflow_reg;
  assign bus.halt           = halt_reg;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_io_responder_if bus ();

  mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8), .FULL_MARGIN(2)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.cpu_a = a; bus.cpu_wr = 1'b1; bus.cpu_dout = d;
    step();
  endtask

  task automatic rd(input logic [31:0] a);
    bus.cpu_a = a; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
    step();
  endtask

  initial begin
    bus.cpu_a = 32'h30000; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5C; bus.tx_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    check("rst_cpu_din",  bus.cpu_din, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_full",     bus.io_buffer_full, 0);
    check("rst_halt",     bus.halt, 0);
    check("rst_ovf",      bus.tx_overflow, 0);
    bus.rx_valid = 1'b0;
    rst_n = 1'b1;

    // RAM byte access and address aliasing of bits [31:18]
    wr(32'h01234, 8'hA5);
    rd(32'h01234);  check("ram_rd", bus.cpu_din, 8'hA5);
    rd(32'h41234);  check("ram_alias", bus.cpu_din, 8'hA5);
    wr(32'h1FFFF, 8'h5A);
    rd(32'h1FFFF);  check("ram_top", bus.cpu_din, 8'h5A);
    rd(32'h01234);  check("ram_keep", bus.cpu_din, 8'hA5);
    rd(32'h30001);  check("io_other_rd", bus.cpu_din, 8'h00);

    // UART output: zero byte is not queued
    wr(32'h30000, 8'h48);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h69);
    check("tx_valid_h", bus.tx_valid, 1);
    check("tx_head_h",  bus.tx_data, 8'h48);
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h0; bus.tx_ready = 1'b1;
    step();
    check("tx_head_i",  bus.tx_data, 8'h69);
    check("tx_valid_i", bus.tx_valid, 1);
    step();
    check("tx_empty",   bus.tx_valid, 0);
    bus.tx_ready = 1'b0;

    // Near-full threshold and full FIFO
    for (int i = 1; i <= 8; i++) begin
      wr(32'h30000, 8'(i));
      if (i == 5) check("full_after5", bus.io_buffer_full, 0);
      if (i == 6) check("full_after6", bus.io_buffer_full, 1);
    end
    // Push with simultaneous pop while full
    bus.tx_ready = 1'b1;
    wr(32'h30000, 8'h0A);
    check("pushpop_ovf",  bus.tx_overflow, 0);
    check("pushpop_head", bus.tx_data, 8'h02);
    check("pushpop_full", bus.io_buffer_full, 1);
    bus.tx_ready = 1'b0;
    wr(32'h30000, 8'h09);
    check("overflow_set", bus.tx_overflow, 1);
    // Drain: contents must be 2..8 then 0x0A, with 0x09 absent
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h0; bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain", bus.tx_data, (i < 7) ? 32'(i + 2) : 32'h0A);
      step();
    end
    check("drain_empty", bus.tx_valid, 0);
    check("drain_full",  bus.io_buffer_full, 0);
    bus.tx_ready = 1'b0;

    // UART input
    bus.rx_valid = 1'b1; bus.rx_data = 8'h37; bus.cpu_a = 32'h30000; bus.cpu_wr = 1'b0;
    #1;
    check("rx_ready_hi", bus.rx_ready, 1);
    step();
    check("rx_data", bus.cpu_din, 8'h37);
    bus.rx_valid = 1'b0;
    #1;
    check("rx_ready_lo", bus.rx_ready, 0);
    step();
    check("rx_none", bus.cpu_din, 8'h00);

    // Cycle counter snapshot 100 cycles after reset release
    rst_n = 1'b0; bus.cpu_a = 32'h0;
    step();
    rst_n = 1'b1;
    repeat (100) step();
    rd(32'h30004); check("cnt_b0", bus.cpu_din, 8'h64);
    rd(32'h30005); check("cnt_b1", bus.cpu_din, 8'h00);
    rd(32'h30006); check("cnt_b2", bus.cpu_din, 8'h00);
    rd(32'h30007); check("cnt_b3", bus.cpu_din, 8'h00);

    // Counter wrap from all-ones
    force dut.cycle_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_reg;
    rd(32'h30004); check("wrap_b0", bus.cpu_din, 8'hFF);
    rd(32'h30007); check("wrap_b3", bus.cpu_din, 8'hFF);
    rd(32'h30004); check("wrap_after_b0", bus.cpu_din, 8'h01);
    rd(32'h30007); check("wrap_after_b3", bus.cpu_din, 8'h00);

    // Program stop
    wr(32'h30004, 8'h01);
    check("halt_set",  bus.halt, 1);
    check("halt_tx_v", bus.tx_valid, 1);
    check("halt_tx_d", bus.tx_data, 8'h00);
    wr(32'h30000, 8'h78);
    bus.cpu_wr = 1'b0; bus.cpu_a = 32'h0; bus.tx_ready = 1'b1;
    step();
    check("halt_ignore", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;
    wr(32'h00100, 8'h77);
    rd(32'h00100); check("halt_ram", bus.cpu_din, 8'h77);
    check("halt_sticky", bus.halt, 1);

    // Mid-operation reset with an io read in flight
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5C; bus.cpu_a = 32'h30000; bus.cpu_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2_rx_ready", bus.rx_ready, 0);
    step();
    check("rst2_cpu_din",  bus.cpu_din, 0);
    check("rst2_halt",     bus.halt, 0);
    check("rst2_tx_valid", bus.tx_valid, 0);
    check("rst2_ovf",      bus.tx_overflow, 0);
    check("rst2_full",     bus.io_buffer_full, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus. It serves the address/data/write-strobe interface that the CPU core initiates, with 1-cycle read latency and 0-cycle write acceptance. It backs `0x00000`–`0x1FFFF` with an internal 128 KB byte RAM and implements the I/O map at `mem_a[17:16]==2'b11`: UART input/output, the cycle counter and the program-stop port. It also generates `io_buffer_full` back to the CPU.

## Interface
- `ADDR_WIDTH`, default 17: RAM byte-address width, giving 2^17 bytes.
- `TX_DEPTH`, default 8: TX FIFO entries. Must be a power of two, ≥4.
- `FULL_MARGIN`, default 2: `io_buffer_full` asserts when free TX entries ≤ FULL_MARGIN.
- `clk_in`  in  1  sole clock.
- `rst_in`  in  1  synchronous, active-low reset.
- `cpu_a`  in  32  CPU address; only [17:0] decoded.
- `cpu_wr`  in  1  1 = write, 0 = read. Every cycle is an access.
- `cpu_dout`  in  8  write data from the CPU.
- `cpu_din`  out  8  read data to the CPU. Valid the cycle after the address.
- `io_buffer_full`  out  1  TX FIFO near-full, to the CPU.
- `rx_valid`  in  1  input byte available.
- `rx_data`  in  8  input byte.
- `rx_ready`  out  1  combinational; consumes `rx_data` this cycle.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  sink accepts head this cycle.
- `halt`  out  1  sticky; program stop written.
- `tx_overflow`  out  1  sticky; a TX push was dropped.

## Operation
- **Decode.** `io = (cpu_a[17:16]==2'b11)`. A non-io access goes to RAM at `cpu_a[ADDR_WIDTH-1:0]`. Bits [31:18] are ignored.
- **RAM write.** At the edge, `ram[a] <= cpu_dout`.
- **RAM read.** At the edge, `cpu_din <= ram[a]`. A read of an address written in the previous cycle returns the new data.
- **Read `0x30000`.**
  - If `rx_valid`: `rx_ready=1` and `cpu_din <=` `rx_data`.
  - Else `cpu_din <= 0x00` and `rx_ready=0`.
  - One byte is consumed per read cycle.
- **Cycle counter.** `cycle_cnt` is 32 bits: 0 at reset, +1 every cycle, wraps at 2^32.
- **Read `0x30004`.** Snapshots `snap <= cycle_cnt` and returns `cycle_cnt[7:0]`.
- **Read `0x30005`/`0x30006`/`0x30007`.** Returns `snap[15:8]`, `[23:16]`, `[31:24]` respectively.
- **Other io reads** return 0x00. **Other io writes** are ignored.
- **Write `0x30000`.** Pushes `cpu_dout` to the TX FIFO. A value of 0x00 is ignored.
- **Write `0x30004`.**
  - Pushes 0x00 to the TX FIFO and sets `halt`.
  - Once `halt=1`, all subsequent io writes are ignored. RAM writes still execute.
- **TX FIFO.** Circular buffer with `head`/`tail` of log2(TX_DEPTH) bits that wrap, and `count` of log2(TX_DEPTH)+1 bits.
  - Pop when `tx_valid && tx_ready`.
  - A push is accepted if `count<TX_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and `tx_overflow` is set.
- **`io_buffer_full`** is registered: `(TX_DEPTH - count_next) <= FULL_MARGIN`.

## Timing
- **Reset values** (synchronous; applied while `rst_in==0` at the edge): `cpu_din`=0, `tx_valid`=0, `io_buffer_full`=0, `halt`=0, `tx_overflow`=0, `cycle_cnt`=0, `snap`=0, FIFO empty.
  - `rx_ready`=0 during reset.
  - RAM contents are not reset.
- **Reset mid-operation.** The FIFO is emptied, queued bytes are lost, and an in-flight read returns 0.
- **Read latency.** Exactly 1 cycle for RAM and io alike. There is no wait state and no busy signal.
- **Write effect.**
  - RAM data is visible on a read issued the next cycle.
  - A TX push is visible on `tx_valid` the next cycle.
  - `halt` rises the cycle after the `0x30004` write.
- **`tx_data`/`tx_valid`** are driven from registered FIFO state; there is no combinational path from `cpu_*` to them.
- **Simultaneous push and pop on a full FIFO.** Both occur, `count` is unchanged, and there is no overflow.
- **Simultaneous push and pop on an empty FIFO.** No pop, since `tx_valid=0`; the push lands.
- **`cycle_cnt` sampling.** A `0x30004` read returns the value before that edge's increment.

## Test plan
- **RAM byte.** Write 0xA5 to `0x01234`, then read `0x01234` the next cycle → `cpu_din`=0xA5 one cycle later. Read `0x41234`, which has bits [31:18] set → also 0xA5.
- **UART output.**
  - With `tx_ready=0`, write 'H', 0x00, 'i' to `0x30000` → FIFO holds 2 entries, `tx_data`='H'.
  - Raise `tx_ready` → 'H' then 'i' are emitted on consecutive cycles.
- **Near-full and overflow.** Hold `tx_ready=0` and write 6 bytes → `io_buffer_full`=1 after the 6th. A 9th write sets `tx_overflow` and FIFO contents are unchanged. A push with a simultaneous pop while full → no overflow.
- **Input.**
  - With `rx_valid=1`, `rx_data`=0x37, read `0x30000` → `rx_ready` high that cycle, `cpu_din`=0x37 next cycle.
  - With `rx_valid=0` → `cpu_din`=0x00 and `rx_ready`=0.
- **Counter.** 100 cycles after reset release, read `0x30004`–`0x30007` on consecutive cycles → the bytes form a single snapshot equal to the cycle index of the `0x30004` read. Force `cycle_cnt`=0xFFFFFFFF → wraps to 0.
- **Stop.**
  - Write 0x01 to `0x30004` → `halt`=1 next cycle and 0x00 is queued on TX.
  - A later write of 'x' to `0x30000` is ignored.
  - Asserting `rst_in=0` for one cycle → all outputs return to their reset values.
